// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: drains a show-ahead FIFO and sends each word as an async serial frame.
module fifo_uart_tx #(
  parameter int B            = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tx_en,
  input  logic         fifo_empty,
  input  logic [B-1:0] fifo_rd_data,
  output logic         fifo_rd,
  output logic         tx,
  output logic         busy,
  output logic         frame_done
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(B) + 1;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [B-1:0]   shift_q, shift_d;
  logic           par_q, par_d, tx_q, tx_d;
  logic           bit_end, last_stop, launch;
  always_comb begin
    bit_end   = cnt_q == CW'(CLKS_PER_BIT - 1);
    last_stop = state_q == STOP && bit_end && bit_q == BW'(STOP_BITS - 1);
    launch    = (state_q == IDLE || last_stop) && tx_en && !fifo_empty;
    state_d   = state_q;
    cnt_d     = (state_q == IDLE || bit_end) ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    shift_d   = shift_q;
    par_d     = par_q;
    case (state_q)
      START:  if (bit_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA:   if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d   = (bit_q == BW'(B - 1)) ? '0 : bit_q + 1'b1;
        if (bit_q == BW'(B - 1)) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        bit_d   = '0;
      end
      STOP:   if (bit_end) begin
        bit_d = bit_q + 1'b1;
        if (last_stop) state_d = IDLE;
      end
      default: ;
    endcase
    // a launch from the last stop bit overrides the return to IDLE (back-to-back frames)
    if (launch) begin
      state_d = START;
      shift_d = fifo_rd_data;
      par_d   = ^fifo_rd_data;
      cnt_d   = '0;
      bit_d   = '0;
    end
    tx_d = state_d == START  ? 1'b0 :
           state_d == DATA   ? shift_d[0] :
           state_d == PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end
  assign fifo_rd    = launch && !reset;
  assign tx         = tx_q;
  assign busy       = state_q != IDLE;
  assign frame_done = last_stop;
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Drains words from the team's synchronous FIFO, on its read side, and transmits each word as an asynchronous serial frame.
- Frame format: start bit, data LSB first, optional even parity, 1 or 2 stop bits.
- Connects directly to the FIFO's rd / empty / rd_data. It is the consumer matching the FIFO's producer-side wr / full / wr_data.

Parameters:
- B, 8: data word width; must match the FIFO word width.
- CLKS_PER_BIT, 16: clock cycles per serial bit; minimum 2.
- PARITY_EN, 0: 1 inserts an even-parity bit after the data bits.
- STOP_BITS, 1: number of stop bits; legal values are 1 or 2.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- tx_en  input  1  permits starting a new frame; does not abort a frame in progress.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_data  input  B  FIFO head word; valid whenever fifo_empty=0 (show-ahead).
- fifo_rd  output  1  pop strobe to FIFO; one cycle per word.
- tx  output  1  serial line; idles high; registered.
- busy  output  1  high whenever the state is not IDLE.
- frame_done  output  1  one-cycle pulse in the final cycle of the last stop bit.

Behaviour:
- Interface decision: one clock, clk; reset is asynchronous and active-high, named reset.
- Reset (async, takes effect immediately, including mid-frame):
  - state=IDLE, tx=1, busy=0, frame_done=0, fifo_rd=0.
  - Shift register, bit counter and baud counter cleared.
  - The partial frame is abandoned; no word is popped during reset.
- State machine: IDLE, START, DATA, PARITY, STOP.
  - A baud counter counts 0..CLKS_PER_BIT-1 within each bit.
  - "Bit end" means counter = CLKS_PER_BIT-1.
- fifo_rd is combinational.
  - It equals (launch condition) AND tx_en AND NOT fifo_empty AND NOT reset.
  - It is never asserted while fifo_empty=1.
- Launch condition: state=IDLE, or state=STOP at the bit end of the last stop bit.
- Launch edge, when the launch condition holds with tx_en=1 and fifo_empty=0:
  - fifo_rd_data is latched into the shift register.
  - fifo_rd=1 in that same cycle.
  - Next state is START; tx becomes 0 on that edge; the baud counter resets.
- START: tx=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx = shift[0] for CLKS_PER_BIT cycles per bit.
  - Shift right at each bit end.
  - After B bits, go to PARITY if PARITY_EN=1, else STOP.
- PARITY:
  - tx = XOR of the latched word (even parity: total count of ones, including the parity bit, is even).
  - Lasts CLKS_PER_BIT cycles, then STOP.
- STOP:
  - tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - frame_done=1 only in the final cycle.
  - At that bit end, either launch the next word (back-to-back, zero idle gap, START begins on the next cycle) or go to IDLE.
- Frame length is (1+B+PARITY_EN+STOP_BITS)*CLKS_PER_BIT cycles, measured from the launch edge to the next possible launch edge.
- tx_en:
  - Sampled only at launch points.
  - Deasserting it mid-frame lets the frame finish; no further pop follows.
- FIFO becoming empty mid-frame has no effect on the current frame (the word is already latched).
- fifo_rd_data changing after launch is ignored.
- No word is popped twice or skipped: exactly one fifo_rd pulse per transmitted frame.

Test Plan:
- Basic frame (CLKS_PER_BIT=4, PARITY_EN=0, STOP_BITS=1):
  - FIFO holds 0xA5, tx_en=1.
  - Exactly one fifo_rd pulse.
  - tx sequence, 4 cycles each: 0 | 1,0,1,0,0,1,0,1 | 1.
  - busy high for 40 cycles; frame_done pulses in cycle 40; tx=1 afterwards.
- Back-to-back:
  - FIFO holds 0x00, 0xFF, 0x3C.
  - Three frames with no idle cycle between stop and start.
  - fifo_rd pulses exactly 40 cycles apart; FIFO empty after the third pop; then IDLE.
- Parity and two stop bits (PARITY_EN=1, STOP_BITS=2):
  - Word 0x07: parity bit 1. Word 0xA5: parity bit 0.
  - Stop high for 8 cycles; frame length 48 cycles.
- Flow control:
  - tx_en=0 with FIFO non-empty: no fifo_rd, tx=1, busy=0.
  - Drop tx_en mid-frame: the current frame completes, then no pop.
  - Empty FIFO with tx_en=1: fifo_rd stays 0 indefinitely.
- Reset mid-frame:
  - Assert reset during DATA bit 3.
  - tx=1 and busy=0 immediately (asynchronous).
  - After release with FIFO non-empty, a new full frame starts from START with the next FIFO word.
- End-to-end with the FIFO:
  - Write 16 words (0,2,…,30) until full.
  - The serial output decodes to the same 16 words in order.
  - FIFO empty flag asserts after the 16th pop.
